// File: rtl/ysyx_22040175_mem_arbiter_if.sv
// Bundle of the IF, LSU and memory handshake buses around the memory arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding core and memory.
interface ysyx_22040175_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [AW-1:0]   if_req_addr;
    logic            if_rsp_valid;
    logic [DW-1:0]   if_rsp_data;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_req_addr;
    logic            lsu_req_wen;
    logic [DW-1:0]   lsu_req_wdata;
    logic [DW/8-1:0] lsu_req_wmask;
    logic            lsu_rsp_valid;
    logic [DW-1:0]   lsu_rsp_data;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_wen;
    logic [DW-1:0]   mem_req_wdata;
    logic [DW/8-1:0] mem_req_wmask;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_data;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/ysyx_22040175_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one outstanding transaction at a time, with a watchdog that aborts hung transactions.
module ysyx_22040175_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    ysyx_22040175_mem_arbiter_if.slave        bus,
    output logic                              busy,
    output logic                              owner,
    output logic                              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state;
    logic            last_owner;
    logic [CW-1:0]   cnt;
    logic            mem_valid_q;
    logic [AW-1:0]   addr_q;
    logic            wen_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;

    logic            grant_if;
    logic            grant_lsu;
    logic            wdog_hit;
    logic            rsp_fire;
    logic            wdog_abort;
    logic            done;

    // Under contention the requester that did not win last time gets the port.
    always_comb begin
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.if_req_valid && bus.lsu_req_valid) begin
                grant_lsu = (last_owner == 1'b0);
                grant_if  = (last_owner == 1'b1);
            end else begin
                grant_if  = bus.if_req_valid;
                grant_lsu = bus.lsu_req_valid;
            end
        end
    end

    // The watchdog fires in the cycle whose increment would bring the count to TIMEOUT_CYCLES;
    // a genuine memory response in that same cycle wins over the abort.
    assign wdog_hit   = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (cnt == CNT_LAST);
    assign rsp_fire   = (state == RESP) && bus.mem_rsp_valid && !rst;
    assign wdog_abort = wdog_hit && !rsp_fire && !rst;
    assign done       = rsp_fire || wdog_abort;

    assign bus.if_req_ready  = grant_if;
    assign bus.lsu_req_ready = grant_lsu;

    assign bus.if_rsp_valid  = done && !owner;
    assign bus.if_rsp_data   = (rsp_fire && !owner) ? bus.mem_rsp_data : '0;
    assign bus.lsu_rsp_valid = done && owner;
    assign bus.lsu_rsp_data  = (rsp_fire && owner && !wen_q) ? bus.mem_rsp_data : '0;

    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wmask = wmask_q;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            owner       <= 1'b0;
            last_owner  <= 1'b0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_lsu) begin
                        owner       <= grant_lsu;
                        last_owner  <= grant_lsu;
                        cnt         <= '0;
                        mem_valid_q <= 1'b1;
                        state       <= REQ;
                        if (grant_lsu) begin
                            addr_q  <= bus.lsu_req_addr;
                            wen_q   <= bus.lsu_req_wen;
                            wdata_q <= bus.lsu_req_wdata;
                            wmask_q <= bus.lsu_req_wmask;
                        end else begin
                            addr_q  <= bus.if_req_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (wdog_abort) begin
                        state       <= IDLE;
                        mem_valid_q <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (bus.mem_req_ready) begin
                        state       <= RESP;
                        mem_valid_q <= 1'b0;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (rsp_fire) begin
                        state <= IDLE;
                    end else if (wdog_abort) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040175_mem_arbiter.sv
// Directed testbench for the memory arbiter: expected responses go into a scoreboard queue
// when the memory side is driven and are matched when a requester sees its response strobe.
module tb_ysyx_22040175_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic          own;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic owner;
    logic timeout_err;

    rsp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    logic tbLastOwner = 1'b0;

    ysyx_22040175_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ysyx_22040175_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ifv, input logic [AW-1:0] ifa,
                                 input logic lv, input logic [AW-1:0] la, input logic lw,
                                 input logic [DW-1:0] wd, input logic [DW/8-1:0] wm);
        bus.if_req_valid  = ifv;
        bus.if_req_addr   = ifa;
        bus.lsu_req_valid = lv;
        bus.lsu_req_addr  = la;
        bus.lsu_req_wen   = lw;
        bus.lsu_req_wdata = wd;
        bus.lsu_req_wmask = wm;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    // Any response strobe must match the oldest scoreboard entry.
    task automatic observeRsp();
        rsp_t got;
        rsp_t exp;
        if (bus.if_rsp_valid || bus.lsu_rsp_valid) begin
            checkOutput("rsp_both_strobes", bus.if_rsp_valid && bus.lsu_rsp_valid, 1'b0);
            checkOutput("rsp_expected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
                got.own  = bus.lsu_rsp_valid;
                got.data = bus.lsu_rsp_valid ? bus.lsu_rsp_data : bus.if_rsp_data;
                exp      = expQ.pop_front();
                checkOutput("rsp_owner", got.own, exp.own);
                checkOutput("rsp_data", got.data, exp.data);
            end
        end
    endtask

    task automatic settle();
        #1;
        observeRsp();
    endtask

    // Runs one full transaction starting in an IDLE cycle with requests already driven.
    task automatic doTxn(input string tag, input int stall, input logic spur, input logic hold,
                         input logic [DW-1:0] rdata);
        logic            expOwn;
        logic [AW-1:0]   eAddr;
        logic            eWen;
        logic [DW-1:0]   eWd;
        logic [DW/8-1:0] eMk;
        if (bus.if_req_valid && bus.lsu_req_valid) expOwn = ~tbLastOwner;
        else expOwn = bus.lsu_req_valid;
        eAddr = expOwn ? bus.lsu_req_addr : bus.if_req_addr;
        eWen  = expOwn & bus.lsu_req_wen;
        eWd   = expOwn ? bus.lsu_req_wdata : '0;
        eMk   = expOwn ? bus.lsu_req_wmask : '0;
        settle();
        checkOutput({tag, ":if_req_ready"}, bus.if_req_ready, !expOwn);
        checkOutput({tag, ":lsu_req_ready"}, bus.lsu_req_ready, expOwn);
        tbLastOwner = expOwn;
        clockEdge();
        if (!hold) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i <= stall; i++) begin
            bus.mem_req_ready = (i == stall);
            bus.mem_rsp_valid = spur;
            bus.mem_rsp_data  = 32'h5A5A_0000 + DW'(i);
            settle();
            checkOutput({tag, ":mem_req_valid"}, bus.mem_req_valid, 1'b1);
            checkOutput({tag, ":mem_req_addr"}, bus.mem_req_addr, eAddr);
            checkOutput({tag, ":mem_req_wen"}, bus.mem_req_wen, eWen);
            checkOutput({tag, ":mem_req_wdata"}, bus.mem_req_wdata, eWd);
            checkOutput({tag, ":mem_req_wmask"}, bus.mem_req_wmask, eMk);
            checkOutput({tag, ":owner"}, owner, expOwn);
            checkOutput({tag, ":busy"}, busy, 1'b1);
            checkOutput({tag, ":no_rsp_in_req"}, bus.if_rsp_valid | bus.lsu_rsp_valid, 1'b0);
            clockEdge();
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = rdata;
        expQ.push_back({expOwn, (expOwn && eWen) ? {DW{1'b0}} : rdata});
        settle();
        checkOutput({tag, ":if_rsp_valid"}, bus.if_rsp_valid, !expOwn);
        checkOutput({tag, ":lsu_rsp_valid"}, bus.lsu_rsp_valid, expOwn);
        checkOutput({tag, ":mem_req_valid_resp"}, bus.mem_req_valid, 1'b0);
        clockEdge();
        bus.mem_rsp_valid = 1'b0;
        settle();
        checkOutput({tag, ":busy_after"}, busy, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        rst = 1'b1;
        clockEdge();
        clockEdge();
        rst = 1'b0;
        settle();
        checkOutput("reset:busy", busy, 1'b0);
        checkOutput("reset:owner", owner, 1'b0);
        checkOutput("reset:mem_req_valid", bus.mem_req_valid, 1'b0);
        checkOutput("reset:mem_req_addr", bus.mem_req_addr, 32'h0);
        checkOutput("reset:timeout_err", timeout_err, 1'b0);
        checkOutput("reset:if_rsp_valid", bus.if_rsp_valid, 1'b0);
        checkOutput("reset:lsu_rsp_valid", bus.lsu_rsp_valid, 1'b0);

        // Contention straight after reset: LSU, IF, LSU.
        applyStimulus(1'b1, 32'h8000_0010, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0);
        doTxn("cont1", 0, 1'b0, 1'b1, 32'h1111_0001);
        checkOutput("cont1:last_owner", tbLastOwner, 1'b1);
        doTxn("cont2", 0, 1'b0, 1'b1, 32'h2222_0002);
        checkOutput("cont2:last_owner", tbLastOwner, 1'b0);
        doTxn("cont3", 0, 1'b0, 1'b1, 32'h3333_0003);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        clockEdge();

        // Lone IF read.
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, '0, '0);
        doTxn("ifread", 0, 1'b0, 1'b0, 32'hDEAD_BEEF);

        // LSU write with memory stalling five cycles.
        applyStimulus(1'b0, '0, 1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'hF);
        doTxn("lsuwr", 5, 1'b0, 1'b0, 32'hCAFE_F00D);

        // Spurious memory responses in IDLE and REQ.
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBAD0_BAD0;
        settle();
        checkOutput("spur_idle:if_rsp_valid", bus.if_rsp_valid, 1'b0);
        checkOutput("spur_idle:lsu_rsp_valid", bus.lsu_rsp_valid, 1'b0);
        clockEdge();
        bus.mem_rsp_valid = 1'b0;
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, '0, 1'b0, '0, '0);
        doTxn("spur_req", 2, 1'b1, 1'b0, 32'h0BAD_F00D);

        // Memory answers in the very cycle the watchdog would fire: normal response wins.
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, '0, 1'b0, '0, '0);
        settle();
        checkOutput("prec:if_req_ready", bus.if_req_ready, 1'b1);
        tbLastOwner = 1'b0;
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        for (int k = 1; k <= TO; k++) begin
            bus.mem_req_ready = (k == 1);
            bus.mem_rsp_valid = (k == TO);
            bus.mem_rsp_data  = 32'hA5A5_1234;
            if (k == TO) expQ.push_back({1'b0, 32'hA5A5_1234});
            settle();
            checkOutput("prec:if_rsp_valid", bus.if_rsp_valid, k == TO);
            checkOutput("prec:busy", busy, 1'b1);
            clockEdge();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        settle();
        checkOutput("prec:busy_after", busy, 1'b0);
        checkOutput("prec:timeout_err", timeout_err, 1'b0);

        // Memory never responds: abort with zero data on the eighth busy cycle.
        applyStimulus(1'b1, 32'h8000_0080, 1'b0, '0, 1'b0, '0, '0);
        settle();
        checkOutput("wdog:if_req_ready", bus.if_req_ready, 1'b1);
        tbLastOwner = 1'b0;
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        for (int k = 1; k <= TO; k++) begin
            bus.mem_req_ready = (k == 1);
            if (k == TO) expQ.push_back({1'b0, 32'h0});
            settle();
            checkOutput("wdog:if_rsp_valid", bus.if_rsp_valid, k == TO);
            checkOutput("wdog:err_not_yet", timeout_err, 1'b0);
            clockEdge();
        end
        bus.mem_req_ready = 1'b0;
        settle();
        checkOutput("wdog:busy_after", busy, 1'b0);
        checkOutput("wdog:mem_req_valid_after", bus.mem_req_valid, 1'b0);
        checkOutput("wdog:timeout_err", timeout_err, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 32'h0000_0300, 1'b0, '0, '0);
        doTxn("after_wdog", 1, 1'b0, 1'b0, 32'h7777_8888);
        checkOutput("after_wdog:timeout_err_sticky", timeout_err, 1'b1);

        // Reset while waiting in RESP: no response, late memory strobe ignored, error cleared.
        applyStimulus(1'b1, 32'h8000_00C0, 1'b0, '0, 1'b0, '0, '0);
        settle();
        clockEdge();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
        bus.mem_req_ready = 1'b1;
        settle();
        clockEdge();
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        settle();
        checkOutput("rstmid:if_rsp_valid_in_rst", bus.if_rsp_valid, 1'b0);
        clockEdge();
        rst = 1'b0;
        tbLastOwner = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h1111_2222;
        settle();
        checkOutput("rstmid:busy", busy, 1'b0);
        checkOutput("rstmid:mem_req_valid", bus.mem_req_valid, 1'b0);
        checkOutput("rstmid:if_rsp_valid", bus.if_rsp_valid, 1'b0);
        checkOutput("rstmid:lsu_rsp_valid", bus.lsu_rsp_valid, 1'b0);
        checkOutput("rstmid:timeout_err", timeout_err, 1'b0);
        clockEdge();
        bus.mem_rsp_valid = 1'b0;
        settle();

        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040175_mem_arbiter.md
Name: ysyx_22040175_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IF, read-only) and the load/store requester (LSU, read/write) of the RV core.
- Accepts one request at a time, registers it, and drives it onto the memory port with a valid/ready handshake.
- Waits for the single response and routes it back to the requester that owns the transaction.
- Round-robin under contention, with a watchdog that aborts hung transactions.

Parameters:
- AW, 32, address width (matches CPU_WIDTH).
- DW, 32, data width (matches CPU_WIDTH).
- TIMEOUT_CYCLES, 256, cycles allowed in REQ+RESP before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  AW  IF read address
- if_rsp_valid  out  1  IF response strobe, one cycle
- if_rsp_data  out  DW  IF read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  AW  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DW  write data
- lsu_req_wmask  in  DW/8  byte write mask
- lsu_rsp_valid  out  1  LSU response strobe (read data or write ack)
- lsu_rsp_data  out  DW  LSU read data (0 for writes)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  registered address
- mem_req_wen  out  1  registered write enable (always 0 for IF)
- mem_req_wdata  out  DW  registered write data
- mem_req_wmask  out  DW/8  registered mask (all 0 for IF)
- mem_rsp_valid  in  1  memory response strobe
- mem_rsp_data  in  DW  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = LSU; valid while busy
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- **FSM states:** IDLE, REQ, RESP. On reset: state=IDLE, all mem_req_* = 0, owner=0, last_owner=IF, timeout counter=0, timeout_err=0.
- **Response outputs:** combinational gates of state and owner, so they are 0 during reset.
- **IDLE arbitration:**
  - Only IF valid: grant IF.
  - Only LSU valid: grant LSU.
  - Both valid: grant the requester that is not last_owner. After reset, the first contention therefore goes to LSU.
  - Winner's req_ready=1 combinationally in the same cycle; the loser's ready is 0. Both readys are 0 outside IDLE.
  - On grant: latch addr/wen/wdata/wmask and owner into registers; last_owner<=winner; counter<=0; next state REQ.
- **REQ:**
  - mem_req_valid=1; all mem_req_* held stable until mem_req_ready=1.
  - On ready: go to RESP.
  - mem_rsp_valid in REQ is ignored.
- **RESP:**
  - Waits for mem_rsp_valid.
  - In that cycle, the owner's rsp_valid=1 and rsp_data=mem_rsp_data, passed through combinationally. For LSU writes, lsu_rsp_data=0. The other requester's rsp_valid stays 0.
  - Next state IDLE.
- **Latency:**
  - Accept at cycle N; mem_req_valid from N+1.
  - Earliest response N+2 (ready at N+1, rsp_valid at N+2).
  - Earliest next accept N+3.
- **Watchdog:**
  - Counter increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES (if nonzero), the FSM goes to IDLE that edge. In that final cycle the owner gets rsp_valid=1 with data 0.
  - mem_req_valid deasserts next cycle; timeout_err<=1 and stays set until rst.
  - A mem_rsp_valid arriving in the same cycle as the timeout takes precedence: normal response, no error.
- **Mid-transaction behaviour:**
  - Requester valid deasserting after acceptance has no effect; the transaction completes.
  - rst mid-transaction: next edge returns to IDLE, mem_req_valid=0, no response delivered.

Test Plan:
- IF read 0x8000_0000 alone, memory ready at once, rsp 0xDEADBEEF one cycle later -> if_req_ready at N; mem_req_valid N+1 with addr 0x8000_0000, wen 0; if_rsp_valid=1, data 0xDEADBEEF at N+2; lsu_rsp_valid stays 0.
- IF and LSU valid together after reset, held for three transactions -> grant order LSU, IF, LSU; last_owner alternates.
- LSU write addr 0x100, wdata 0x12345678, wmask 0xF, mem_req_ready low 5 cycles -> mem_req_* stable all 5 cycles; lsu_rsp_valid=1, lsu_rsp_data=0 on the ack.
- TIMEOUT_CYCLES=8, memory never responds -> owner rsp_valid=1, data 0 at the 8th busy cycle; timeout_err=1 until rst; next request accepted normally.
- rst asserted in RESP -> next cycle state IDLE, busy=0, mem_req_valid=0, no rsp_valid; a late mem_rsp_valid is ignored.
- Spurious mem_rsp_valid in IDLE and REQ -> no rsp_valid to either requester.
